slave_bus_bridge: RTL and testbench

//  Bridge between the SCC68070 bus and the 68HC05 slave microcontroller at 0x31xxxx.
//  - Per CPU access, freezes address, direction and write data onto the slave's port inputs.
//  - Interrupts the slave and waits for its DTACK handshake.
//  - Returns the slave's byte with bus_ack to the CPU, or raises bus_err on timeout.
//  - Sits directly upstream of uc68hc05 and replaces the ad-hoc DTACK/IRQ glue at top level.

---
 rtl/slave_bus_bridge.sv | 172 +++++++++++++++++
 tb/tb_slave_bus_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/slave_bus_bridge.sv
// Bridge between the SCC68070 bus and the 68HC05 slave: latches the CPU access onto the
// slave's ports, pulses the slave IRQ, waits for a DTACK rising edge or times out.
module slave_bus_bridge #(
   parameter int unsigned IRQ_DELAY = 20,
   parameter int unsigned IRQ_PULSE = 1,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        uds,
   input  logic        lds,
   input  logic        write_strobe,
   input  logic [1:0]  addr,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        bus_ack,
   output logic        bus_err,
   output logic [7:0]  slave_porta,
   output logic [1:0]  slave_addr,
   output logic        slave_rw_n,
   output logic        slave_irq_n,
   input  logic [7:0]  slave_data,
   input  logic        slave_dtack_n
);

   localparam int unsigned CNT_W = 16;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DELAY    = 3'd1;
   localparam logic [2:0] ST_IRQ      = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] to_q, to_d;
   logic [15:0]      dout_q, dout_d;
   logic             bus_ack_q, bus_ack_d;
   logic             bus_err_q, bus_err_d;
   logic [7:0]       porta_q, porta_d;
   logic [1:0]       saddr_q, saddr_d;
   logic             rw_n_q, rw_n_d;
   logic             irq_n_q, irq_n_d;
   logic             dtack_q, dtack_d;

   logic             req_c;
   logic             ack_edge_c;
   logic             unused_din;

   // Only the low byte reaches the 8-bit slave port.
   assign unused_din = ^din[15:8];

   assign req_c      = cs && (uds || lds);
   assign ack_edge_c = slave_dtack_n && !dtack_q;

   // Next-state and output logic; a dropped cs aborts any in-flight handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      dout_d    = dout_q;
      bus_ack_d = 1'b0;
      bus_err_d = bus_err_q;
      porta_d   = porta_q;
      saddr_d   = saddr_q;
      rw_n_d    = rw_n_q;
      irq_n_d   = irq_n_q;
      dtack_d   = slave_dtack_n;

      case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               porta_d = din[7:0];
               saddr_d = addr;
               rw_n_d  = !write_strobe;
               cnt_d   = CNT_W'(IRQ_DELAY - 1);
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (!cs) begin
               irq_n_d   = 1'b1;
               bus_err_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (cnt_q == '0) begin
               irq_n_d = 1'b0;
               cnt_d   = CNT_W'(IRQ_PULSE - 1);
               state_d = ST_IRQ;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_IRQ: begin
            if (!cs) begin
               irq_n_d   = 1'b1;
               bus_err_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (cnt_q == '0) begin
               irq_n_d = 1'b1;
               to_d    = '0;
               state_d = ST_WAIT_ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_ACK: begin
            // An ack edge beats a timeout expiring in the same cycle.
            if (!cs) begin
               irq_n_d   = 1'b1;
               bus_err_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (ack_edge_c) begin
               dout_d    = {slave_data, slave_data};
               bus_ack_d = 1'b1;
               state_d   = ST_RELEASE;
            end else if (to_q == CNT_W'(TIMEOUT - 1)) begin
               bus_err_d = 1'b1;
               state_d   = ST_RELEASE;
            end else begin
               to_d = to_q + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (!cs) begin
               bus_err_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         to_q      <= '0;
         dout_q    <= '0;
         bus_ack_q <= 1'b0;
         bus_err_q <= 1'b0;
         porta_q   <= '0;
         saddr_q   <= '0;
         rw_n_q    <= 1'b1;
         irq_n_q   <= 1'b1;
         dtack_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         dout_q    <= dout_d;
         bus_ack_q <= bus_ack_d;
         bus_err_q <= bus_err_d;
         porta_q   <= porta_d;
         saddr_q   <= saddr_d;
         rw_n_q    <= rw_n_d;
         irq_n_q   <= irq_n_d;
         dtack_q   <= dtack_d;
      end
   end

   assign dout        = dout_q;
   assign bus_ack     = bus_ack_q;
   assign bus_err     = bus_err_q;
   assign slave_porta = porta_q;
   assign slave_addr  = saddr_q;
   assign slave_rw_n  = rw_n_q;
   assign slave_irq_n = irq_n_q;

endmodule

// File: tb/tb_slave_bus_bridge.sv
// Directed bench for slave_bus_bridge: two instances share stimulus, one with default
// IRQ timing and TIMEOUT=100, one with a 4-cycle IRQ pulse and TIMEOUT=50.
module tb_slave_bus_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs, uds, lds, write_strobe;
   logic [1:0]  addr;
   logic [15:0] din;
   logic [7:0]  slave_data;
   logic        slave_dtack_n;

   logic [15:0] dout_a, dout_b;
   logic        ack_a, ack_b, err_a, err_b;
   logic [7:0]  porta_a, porta_b;
   logic [1:0]  saddr_a, saddr_b;
   logic        rw_a, rw_b, irq_a, irq_b;

   int vectors = 0;
   int miscompares = 0;

   int irq_first [2];
   int irq_cnt   [2];
   int ack_cnt   [2];
   int ack_at    [2];
   int err_at    [2];
   logic [15:0] dout_cap [2];
   logic [10:0] snap1;

   slave_bus_bridge #(.IRQ_DELAY(20), .IRQ_PULSE(1), .TIMEOUT(100)) dut_a (
      .clk(clk), .reset_n(reset_n), .cs(cs), .uds(uds), .lds(lds),
      .write_strobe(write_strobe), .addr(addr), .din(din), .dout(dout_a),
      .bus_ack(ack_a), .bus_err(err_a), .slave_porta(porta_a), .slave_addr(saddr_a),
      .slave_rw_n(rw_a), .slave_irq_n(irq_a), .slave_data(slave_data),
      .slave_dtack_n(slave_dtack_n));

   slave_bus_bridge #(.IRQ_DELAY(20), .IRQ_PULSE(4), .TIMEOUT(50)) dut_b (
      .clk(clk), .reset_n(reset_n), .cs(cs), .uds(uds), .lds(lds),
      .write_strobe(write_strobe), .addr(addr), .din(din), .dout(dout_b),
      .bus_ack(ack_b), .bus_err(err_b), .slave_porta(porta_b), .slave_addr(saddr_b),
      .slave_rw_n(rw_b), .slave_irq_n(irq_b), .slave_data(slave_data),
      .slave_dtack_n(slave_dtack_n));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         irq_first[i] = -1; irq_cnt[i] = 0; ack_cnt[i] = 0;
         ack_at[i] = -1; err_at[i] = -1; dout_cap[i] = '0;
      end
   endtask

   task automatic rec(input int i, input int k, input logic irq_n, input logic ack,
                      input logic err, input logic [15:0] d);
      if (!irq_n) begin
         if (irq_first[i] < 0) irq_first[i] = k;
         irq_cnt[i]++;
      end
      if (ack) begin
         if (ack_at[i] < 0) begin ack_at[i] = k; dout_cap[i] = d; end
         ack_cnt[i]++;
      end
      if (err && err_at[i] < 0) err_at[i] = k;
   endtask

   // n clock edges; dtack_n pulses high for one cycle before edges p1 and p2 (0 = none).
   task automatic run(input int n, input int p1, input int p2);
      for (int k = 1; k <= n; k++) begin
         slave_dtack_n = (k == p1) || (k == p2);
         @(posedge clk); #1;
         if (k == 1) snap1 = {porta_a, saddr_a, rw_a};
         rec(0, k, irq_a, ack_a, err_a, dout_a);
         rec(1, k, irq_b, ack_b, err_b, dout_b);
      end
      slave_dtack_n = 1'b0;
   endtask

   task automatic start(input logic wr, input logic [1:0] a, input logic [15:0] d);
      write_strobe = wr; addr = a; din = d;
      cs = 1'b1; uds = 1'b1; lds = 1'b1;
      clr();
   endtask

   task automatic release_bus();
      cs = 1'b0; uds = 1'b0; lds = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0; cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
      addr = '0; din = '0; slave_data = '0; slave_dtack_n = 1'b0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout_a), 32'h0);
      chk("rst_ack_err", {30'd0, ack_a, err_a}, 32'h0);
      chk("rst_porta_addr", {22'd0, porta_a, saddr_a}, 32'h0);
      chk("rst_rw_irq", {30'd0, rw_a, irq_a}, 32'h3);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Read, dtack 10 cycles after the IRQ.
      slave_data = 8'h5A;
      start(1'b0, 2'b01, 16'h00C3);
      run(40, 32, 0);
      chk("t1_irq_first_a", irq_first[0], 21);
      chk("t1_irq_cnt_a", irq_cnt[0], 1);
      chk("t1_irq_first_b", irq_first[1], 21);
      chk("t1_irq_cnt_b", irq_cnt[1], 4);
      chk("t1_ack_at_a", ack_at[0], 32);
      chk("t1_ack_cnt_a", ack_cnt[0], 1);
      chk("t1_dout_a", 32'(dout_cap[0]), 32'h5A5A);
      chk("t1_ack_at_b", ack_at[1], 32);
      chk("t1_no_err_a", err_at[0], -1);
      chk("t1_addr_rw", {29'd0, saddr_a, rw_a}, {29'd0, 2'b01, 1'b1});
      release_bus();

      // Write: latched slave port values visible from cycle 1 and held.
      slave_data = 8'h11;
      start(1'b1, 2'b10, 16'h00C3);
      run(40, 32, 0);
      chk("t2_latch_c1", 32'(snap1), {21'd0, 8'hC3, 2'b10, 1'b0});
      chk("t2_ack_at", ack_at[0], 32);
      chk("t2_ack_cnt", ack_cnt[0], 1);
      chk("t2_dout", 32'(dout_cap[0]), 32'h1111);
      release_bus();
      chk("t2_latch_hold", {21'd0, porta_a, saddr_a, rw_a}, {21'd0, 8'hC3, 2'b10, 1'b0});

      // No dtack at all: timeout.
      start(1'b0, 2'b00, 16'h00C3);
      run(130, 0, 0);
      chk("t3_err_at_a", err_at[0], 122);
      chk("t3_no_ack_a", ack_cnt[0], 0);
      chk("t3_err_held", 32'(err_a), 32'h1);
      chk("t3_err_at_b", err_at[1], 75);
      cs = 1'b0; uds = 1'b0; lds = 1'b0;
      @(posedge clk); #1;
      chk("t3_err_clear", {30'd0, err_a, err_b}, 32'h0);
      @(posedge clk); #1;

      // Dtack edge during DELAY is ignored.
      start(1'b0, 2'b11, 16'h00C3);
      run(80, 10, 0);
      chk("t4_err_at_b", err_at[1], 75);
      chk("t4_no_ack_b", ack_cnt[1], 0);
      chk("t4_no_ack_a", ack_cnt[0], 0);
      release_bus();

      // Edge coincides with expiry: ack wins.
      slave_data = 8'h3C;
      start(1'b0, 2'b11, 16'h00C3);
      run(80, 10, 75);
      chk("t4b_ack_at_b", ack_at[1], 75);
      chk("t4b_ack_cnt_b", ack_cnt[1], 1);
      chk("t4b_no_err_b", err_at[1], -1);
      chk("t4b_dout_b", 32'(dout_cap[1]), 32'h3C3C);
      chk("t4b_ack_at_a", ack_at[0], 75);
      release_bus();

      // Abort during IRQ.
      start(1'b0, 2'b01, 16'h00C3);
      run(22, 0, 0);
      chk("t5_irq_low_b", 32'(irq_b), 32'h0);
      cs = 1'b0; uds = 1'b0; lds = 1'b0;
      @(posedge clk); #1;
      chk("t5_irq_high_b", 32'(irq_b), 32'h1);
      chk("t5_no_ack_err", {28'd0, ack_a, err_a, ack_b, err_b}, 32'h0);
      @(posedge clk); #1;
      slave_data = 8'h81;
      start(1'b0, 2'b01, 16'h00C3);
      run(40, 32, 0);
      chk("t5_next_ack_a", ack_at[0], 32);
      chk("t5_next_ack_b", ack_at[1], 32);
      chk("t5_next_dout_b", 32'(dout_cap[1]), 32'h8181);
      release_bus();

      // Reset mid WAIT_ACK.
      start(1'b0, 2'b10, 16'h00C3);
      run(30, 0, 0);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_rst_porta", 32'(porta_a), 32'h0);
      chk("t6_rst_rw_irq", {28'd0, rw_a, irq_a, ack_a, err_a}, 32'hC);
      chk("t6_rst_dout", 32'(dout_a), 32'h0);
      cs = 1'b0; uds = 1'b0; lds = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      clr();
      run(150, 0, 0);
      chk("t6_no_ack", ack_cnt[0] + ack_cnt[1], 0);
      chk("t6_no_err", {err_at[0] < 0, err_at[1] < 0}, 32'h3);
      slave_data = 8'hE7;
      start(1'b0, 2'b00, 16'h00C3);
      run(40, 32, 0);
      chk("t6_next_ack", ack_at[0], 32);
      chk("t6_next_dout", 32'(dout_cap[0]), 32'hE7E7);
      release_bus();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
